// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU result stage and its producer/consumer.
// Carries out_parity only when ALU_RESULT_STAGE_PARITY_EN is defined.
interface alu_result_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
`ifdef ALU_RESULT_STAGE_PARITY_EN
    logic             out_parity;
`endif
    logic             sticky_ovf;
    logic             clr_sticky;
    logic [WIDTH-1:0] done_count;

    // Producer/consumer side
    modport master (
`ifdef ALU_RESULT_STAGE_PARITY_EN
        input  out_parity,
`endif
        output in_valid,
        output in_result,
        output in_ovf,
        output out_ready,
        output clr_sticky,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_zero,
        input  out_neg,
        input  out_ovf,
        input  sticky_ovf,
        input  done_count
    );

    // Stage side
    modport slave (
`ifdef ALU_RESULT_STAGE_PARITY_EN
        output out_parity,
`endif
        input  in_valid,
        input  in_result,
        input  in_ovf,
        input  out_ready,
        input  clr_sticky,
        output in_ready,
        output out_valid,
        output out_result,
        output out_zero,
        output out_neg,
        output out_ovf,
        output sticky_ovf,
        output done_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// 2-entry registered output FIFO for ALU results with flags, sticky overflow
// and delivered counter. Define ALU_RESULT_STAGE_PARITY_EN to add out_parity.
module alu_result_stage #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    alu_result_stage_if.slave bus
);
    localparam int DEPTH = 2;

    logic [WIDTH-1:0] res_q  [DEPTH];
    logic [WIDTH-1:0] res_d  [DEPTH];
    logic             zero_q [DEPTH];
    logic             zero_d [DEPTH];
    logic             neg_q  [DEPTH];
    logic             neg_d  [DEPTH];
    logic             ovf_q  [DEPTH];
    logic             ovf_d  [DEPTH];
`ifdef ALU_RESULT_STAGE_PARITY_EN
    logic             par_q  [DEPTH];
    logic             par_d  [DEPTH];
`endif
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] done_q, done_d;

    logic push;
    logic pop;

    // Ready is a pure function of occupancy; no path from out_ready.
    assign push = bus.in_valid && (cnt_q != 2'd2);
    assign pop  = bus.out_ready && (cnt_q != 2'd0);

    always_comb begin
        res_d    = res_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
`ifdef ALU_RESULT_STAGE_PARITY_EN
        par_d    = par_q;
`endif
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = done_q;
        cnt_d    = cnt_q;

        if (push) begin
            res_d[wr_ptr_q]  = bus.in_result;
            zero_d[wr_ptr_q] = (bus.in_result == '0);
            neg_d[wr_ptr_q]  = bus.in_result[WIDTH-1];
            ovf_d[wr_ptr_q]  = bus.in_ovf;
`ifdef ALU_RESULT_STAGE_PARITY_EN
            par_d[wr_ptr_q]  = ^bus.in_result;
`endif
            wr_ptr_d = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            done_d   = done_q + WIDTH'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Set wins over clear in the same cycle.
        sticky_d = (sticky_q && !bus.clr_sticky) || (push && bus.in_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i]  <= '0;
                zero_q[i] <= 1'b0;
                neg_q[i]  <= 1'b0;
                ovf_q[i]  <= 1'b0;
`ifdef ALU_RESULT_STAGE_PARITY_EN
                par_q[i]  <= 1'b0;
`endif
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            sticky_q <= 1'b0;
            done_q   <= '0;
        end else begin
            res_q    <= res_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
`ifdef ALU_RESULT_STAGE_PARITY_EN
            par_q    <= par_d;
`endif
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
        end
    end

    assign bus.in_ready   = (cnt_q != 2'd2);
    assign bus.out_valid  = (cnt_q != 2'd0);
    assign bus.out_result = res_q[rd_ptr_q];
    assign bus.out_zero   = zero_q[rd_ptr_q];
    assign bus.out_neg    = neg_q[rd_ptr_q];
    assign bus.out_ovf    = ovf_q[rd_ptr_q];
`ifdef ALU_RESULT_STAGE_PARITY_EN
    assign bus.out_parity = par_q[rd_ptr_q];
`endif
    assign bus.sticky_ovf = sticky_q;
    assign bus.done_count = done_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue model.
// Checks out_parity as well when ALU_RESULT_STAGE_PARITY_EN is defined.
module tb_alu_result_stage;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(W)) bus ();

    alu_result_stage #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;

    // Model: FIFO of {ovf, result}; flags derived when compared.
    logic [W:0]   mq[$];
    logic         m_sticky;
    logic [W-1:0] m_done;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic [W-1:0] h;
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != 2));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("sticky", 32'(bus.sticky_ovf), 32'(m_sticky));
        chk("done", 32'(bus.done_count), 32'(m_done));
        if (mq.size() != 0) begin
            h = mq[0][W-1:0];
            chk("result", 32'(bus.out_result), 32'(h));
            chk("zero", 32'(bus.out_zero), 32'(h == 0));
            chk("neg", 32'(bus.out_neg), 32'(h >= 16'h8000));
            chk("ovf", 32'(bus.out_ovf), 32'(mq[0][W]));
`ifdef ALU_RESULT_STAGE_PARITY_EN
            chk("parity", 32'(bus.out_parity), 32'($countones(h) % 2));
`endif
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [W-1:0] d,
                       input logic o, input logic rdy, input logic clr);
        bit push;
        bit pop;
        rst            = r;
        bus.in_valid   = v;
        bus.in_result  = d;
        bus.in_ovf     = o;
        bus.out_ready  = rdy;
        bus.clr_sticky = clr;
        push = !r && v && (mq.size() < 2);
        pop  = !r && rdy && (mq.size() > 0);
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_sticky = 1'b0;
            m_done   = '0;
        end else begin
            m_sticky = (m_sticky && !clr) || (push && o);
            if (pop) begin
                void'(mq.pop_front());
                m_done = m_done + 1'b1;
            end
            if (push) mq.push_back({o, d});
        end
        @(negedge clk);
        cmp_all();
    endtask

    logic [W-1:0] rv;

    initial begin
        mq.delete();
        m_sticky = 1'b0;
        m_done   = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        bus.in_ovf = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_sticky = 1'b0;

        // Reset held 2 cycles with in_valid high: nothing stored
        cyc(1, 1, 16'h5555, 1, 0, 0);
        cyc(1, 1, 16'h5555, 1, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0, 0);

        // Single transfer
        cyc(0, 1, 16'h8000, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        chk("single_done", 32'(bus.done_count), 32'd1);

        // Full / backpressure
        cyc(0, 1, 16'h0000, 0, 0, 0);
        cyc(0, 1, 16'h1234, 0, 0, 0);
        cyc(0, 1, 16'hFFFF, 0, 0, 0);
        cyc(0, 1, 16'hFFFF, 0, 0, 0);
        cyc(0, 1, 16'hFFFF, 0, 1, 0);
        cyc(0, 1, 16'hFFFF, 0, 1, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        // Streaming from reset: 20 words, done_count must reach 20
        cyc(1, 0, 16'h0000, 0, 0, 0);
        for (int i = 1; i <= 20; i++) cyc(0, 1, W'(i), 0, 1, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0);
        chk("stream_done", 32'(bus.done_count), 32'd20);

        // Sticky: set wins over clear, then clear
        cyc(0, 1, 16'h7FFF, 1, 1, 1);
        chk("sticky_set", 32'(bus.sticky_ovf), 32'd1);
        cyc(0, 0, 16'h0000, 0, 1, 1);
        chk("sticky_clr", 32'(bus.sticky_ovf), 32'd0);

        // Random traffic with occasional reset and clear
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rv = 16'h0000;
                1: rv = 16'hFFFF;
                2: rv = 16'h8000;
                default: rv = W'($urandom);
            endcase
            cyc(($urandom_range(0, 63) == 0), 1'($urandom), rv,
                1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

`ifdef ALU_RESULT_STAGE_PARITY_EN
        cyc(1, 0, 16'h0000, 0, 0, 0);
        cyc(0, 1, 16'h0007, 0, 0, 0);
        chk("parity7", 32'(bus.out_parity), 32'd1);
`endif

        // Wrap: 65536 pops from reset bring done_count back to zero
        cyc(1, 0, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 65537; i++) cyc(0, 1, W'(i), 0, 1, 0);
        chk("wrap_done", 32'(bus.done_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
